// File: rtl/noise_shaper_pkg.sv
// Shared widths, mode/state encodings, stage shift constants and saturation
// for the noise_shaper filter bank.
package noise_pkg;

  localparam int NOISE_IN_W = 32;
  localparam int SAMPLE_W   = 24;
  localparam int ACC_W      = 32;

  // Leak (L) and gain (G) shifts for each leaky integrator stage.
  localparam int P0_LEAK     = 1;
  localparam int P0_GAIN     = 2;
  localparam int P1_LEAK     = 4;
  localparam int P1_GAIN     = 4;
  localparam int P2_LEAK     = 7;
  localparam int P2_GAIN     = 6;
  localparam int B_LEAK      = 6;
  localparam int B_GAIN      = 4;
  localparam int PINK_W_GAIN = 3;

  typedef enum logic [1:0] {
    MODE_WHITE = 2'b00,
    MODE_PINK  = 2'b01,
    MODE_BROWN = 2'b10,
    MODE_MUTE  = 2'b11
  } mode_e;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_ST0  = 3'd1,
    S_ST1  = 3'd2,
    S_ST2  = 3'd3,
    S_SUM  = 3'd4,
    S_HOLD = 3'd5
  } state_e;

  function automatic logic [SAMPLE_W-1:0] sat24(input logic signed [ACC_W-1:0] x);
    if (x > 32'sh007F_FFFF) begin
      return 24'h7F_FFFF;
    end else if (x < -32'sh0080_0000) begin
      return 24'h80_0000;
    end else begin
      return x[SAMPLE_W-1:0];
    end
  endfunction

endpackage

// File: rtl/noise_shaper_leaky_stage.sv
// Combinational leaky integrator step: acc - (acc >>> L) + (w >>> G),
// two's-complement wrap, arithmetic shifts.
module leaky_stage
  import noise_pkg::*;
#(
  parameter int L = 1,
  parameter int G = 2
) (
  input  logic signed [ACC_W-1:0] acc_i,
  input  logic signed [ACC_W-1:0] w_i,
  output logic signed [ACC_W-1:0] acc_o
);

  assign acc_o = acc_i - (acc_i >>> L) + (w_i >>> G);

endmodule

// File: rtl/noise_shaper.sv
// Shapes one LFSR white-noise word per sample tick into white/pink/brown/mute
// output via a multi-cycle leaky-integrator bank. Brown stage: NOISE_SHAPER_BROWN_EN.
module noise_shaper
  import noise_pkg::*;
(
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  sample_tick,
  input  logic [NOISE_IN_W-1:0] noise_in,
  input  logic [1:0]            mode,
  input  logic                  out_ready,
  output logic [SAMPLE_W-1:0]   sample_out,
  output logic                  out_valid,
  output logic                  busy,
  output logic                  overrun
);

  // state | meaning
  // IDLE  | waiting for sample_tick; captures w and mode
  // ST0   | update pink stage p0
  // ST1   | update pink stage p1
  // ST2   | update pink stage p2 (and brown b)
  // SUM   | form sample_out for latched mode, raise out_valid
  // HOLD  | wait for out_ready handshake

  state_e                  state_q, state_d;
  mode_e                   mode_q, mode_d;
  logic signed [ACC_W-1:0] w_q, w_d;
  logic signed [ACC_W-1:0] p0_q, p0_d, p1_q, p1_d, p2_q, p2_d;
  logic signed [ACC_W-1:0] p0_nxt, p1_nxt, p2_nxt;
  logic signed [ACC_W-1:0] pink_sum;
  logic [SAMPLE_W-1:0]     sample_q, sample_d;
  logic                    valid_q, valid_d;
  logic                    overrun_q, overrun_d;

  leaky_stage #(.L(P0_LEAK), .G(P0_GAIN)) u_p0 (.acc_i(p0_q), .w_i(w_q), .acc_o(p0_nxt));
  leaky_stage #(.L(P1_LEAK), .G(P1_GAIN)) u_p1 (.acc_i(p1_q), .w_i(w_q), .acc_o(p1_nxt));
  leaky_stage #(.L(P2_LEAK), .G(P2_GAIN)) u_p2 (.acc_i(p2_q), .w_i(w_q), .acc_o(p2_nxt));

`ifdef NOISE_SHAPER_BROWN_EN
  logic signed [ACC_W-1:0] b_q, b_d, b_nxt;
  leaky_stage #(.L(B_LEAK), .G(B_GAIN)) u_b (.acc_i(b_q), .w_i(w_q), .acc_o(b_nxt));
`endif

  assign pink_sum = p0_q + p1_q + p2_q + (w_q >>> PINK_W_GAIN);

  always_comb begin
    state_d   = state_q;
    mode_d    = mode_q;
    w_d       = w_q;
    p0_d      = p0_q;
    p1_d      = p1_q;
    p2_d      = p2_q;
`ifdef NOISE_SHAPER_BROWN_EN
    b_d       = b_q;
`endif
    sample_d  = sample_q;
    valid_d   = valid_q;
    overrun_d = sample_tick && (state_q != S_IDLE);
    case (state_q)
      S_IDLE: begin
        if (sample_tick) begin
          w_d     = $signed(noise_in) >>> 8;
          mode_d  = mode_e'(mode);
          state_d = S_ST0;
        end
      end
      S_ST0: begin
        p0_d    = p0_nxt;
        state_d = S_ST1;
      end
      S_ST1: begin
        p1_d    = p1_nxt;
        state_d = S_ST2;
      end
      S_ST2: begin
        p2_d    = p2_nxt;
`ifdef NOISE_SHAPER_BROWN_EN
        b_d     = b_nxt;
`endif
        state_d = S_SUM;
      end
      S_SUM: begin
        case (mode_q)
          MODE_WHITE: sample_d = w_q[SAMPLE_W-1:0];
          MODE_PINK:  sample_d = sat24(pink_sum);
`ifdef NOISE_SHAPER_BROWN_EN
          MODE_BROWN: sample_d = sat24(b_q);
`else
          MODE_BROWN: sample_d = w_q[SAMPLE_W-1:0];
`endif
          MODE_MUTE:  sample_d = '0;
        endcase
        valid_d = 1'b1;
        state_d = S_HOLD;
      end
      S_HOLD: begin
        if (valid_q && out_ready) begin
          valid_d = 1'b0;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= S_IDLE;
      mode_q    <= MODE_WHITE;
      w_q       <= '0;
      p0_q      <= '0;
      p1_q      <= '0;
      p2_q      <= '0;
`ifdef NOISE_SHAPER_BROWN_EN
      b_q       <= '0;
`endif
      sample_q  <= '0;
      valid_q   <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      mode_q    <= mode_d;
      w_q       <= w_d;
      p0_q      <= p0_d;
      p1_q      <= p1_d;
      p2_q      <= p2_d;
`ifdef NOISE_SHAPER_BROWN_EN
      b_q       <= b_d;
`endif
      sample_q  <= sample_d;
      valid_q   <= valid_d;
      overrun_q <= overrun_d;
    end
  end

  assign sample_out = sample_q;
  assign out_valid  = valid_q;
  assign busy       = (state_q != S_IDLE);
  assign overrun    = overrun_q;

endmodule

// File: tb/tb_noise_shaper.sv
// Directed self-checking bench for noise_shaper: latency, filter values,
// saturation, overrun and mid-sample reset.
module tb_noise_shaper;

  logic        clk = 1'b0;
  logic        reset;
  logic        sample_tick;
  logic [31:0] noise_in;
  logic [1:0]  mode;
  logic        out_ready;
  logic [23:0] sample_out;
  logic        out_valid;
  logic        busy;
  logic        overrun;

  int n_cmp = 0;
  int n_err = 0;
  int ovr_cnt = 0;

  noise_shaper dut (
    .clk        (clk),
    .reset      (reset),
    .sample_tick(sample_tick),
    .noise_in   (noise_in),
    .mode       (mode),
    .out_ready  (out_ready),
    .sample_out (sample_out),
    .out_valid  (out_valid),
    .busy       (busy),
    .overrun    (overrun)
  );

  always #5 clk = ~clk;

  always @(negedge clk) if (overrun === 1'b1) ovr_cnt++;

  initial begin
    #2000000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    sample_tick = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
  endtask

  // Returns at the negedge following the accepting edge E0.
  task automatic send(input logic [31:0] n, input logic [1:0] m);
    @(negedge clk);
    noise_in = n;
    mode = m;
    sample_tick = 1'b1;
    @(negedge clk);
    sample_tick = 1'b0;
  endtask

  task automatic get_sample(input string tag, output logic [23:0] s);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (out_valid === 1'b1) begin
        ok = 1'b1;
        break;
      end
    end
    chk({tag, "_valid_seen"}, {31'd0, ok}, 32'd1);
    s = sample_out;
  endtask

  logic [23:0] s;
  logic [23:0] held;
  int          ovr_base;

  initial begin
    reset = 1'b1;
    sample_tick = 1'b0;
    noise_in = '0;
    mode = 2'b00;
    out_ready = 1'b1;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    chk("rst_sample_out", {8'd0, sample_out}, 32'd0);
    chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_overrun", {31'd0, overrun}, 32'd0);

    // White: latency E0+4, busy drops after handshake
    send(32'h1234_5600, 2'b00);
    chk("white_busy_e0", {31'd0, busy}, 32'd1);
    repeat (3) @(negedge clk);
    chk("white_valid_e3", {31'd0, out_valid}, 32'd0);
    @(negedge clk);
    chk("white_valid_e4", {31'd0, out_valid}, 32'd1);
    chk("white_sample", {8'd0, sample_out}, 32'h0012_3456);
    @(negedge clk);
    chk("white_busy_after", {31'd0, busy}, 32'd0);
    chk("white_valid_after", {31'd0, out_valid}, 32'd0);

    // Pink single tick from clean accumulators
    do_reset();
    send(32'h1000_0000, 2'b01);
    get_sample("pink1", s);
    chk("pink1_sample", {8'd0, s}, 32'h0007_4000);

    // Brown (white when the brown stage is not built)
    do_reset();
    send(32'h1000_0000, 2'b10);
    get_sample("brown1", s);
`ifdef NOISE_SHAPER_BROWN_EN
    chk("brown1_sample", {8'd0, s}, 32'h0001_0000);
`else
    chk("brown1_sample", {8'd0, s}, 32'h0010_0000);
`endif

    // Mute
    send(32'h1000_0000, 2'b11);
    get_sample("mute", s);
    chk("mute_sample", {8'd0, s}, 32'd0);

    // Positive saturation
    do_reset();
    for (int i = 0; i < 200; i++) begin
      send(32'h7FFF_FFFF, 2'b01);
      get_sample("satp", s);
      chk("satp_sign", {31'd0, s[23]}, 32'd0);
    end
    chk("satp_final", {8'd0, s}, 32'h007F_FFFF);

    // Negative saturation
    do_reset();
    for (int i = 0; i < 200; i++) begin
      send(32'h8000_0000, 2'b01);
      get_sample("satn", s);
      chk("satn_sign", {31'd0, s[23]}, 32'd1);
    end
    chk("satn_final", {8'd0, s}, 32'h0080_0000);

    // Overruns with out_ready low
    @(negedge clk);
    out_ready = 1'b0;
    ovr_base = ovr_cnt;
    send(32'hABCD_EF00, 2'b00);
    @(negedge clk);
    sample_tick = 1'b1;
    @(negedge clk);
    sample_tick = 1'b0;
    get_sample("ovr", s);
    chk("ovr_sample", {8'd0, s}, 32'h00AB_CDEF);
    held = s;
    sample_tick = 1'b1;
    noise_in = 32'h1111_1100;
    @(negedge clk);
    sample_tick = 1'b0;
    repeat (3) @(negedge clk);
    chk("ovr_count", ovr_cnt - ovr_base, 32'd2);
    chk("ovr_hold_valid", {31'd0, out_valid}, 32'd1);
    chk("ovr_hold_sample", {8'd0, sample_out}, {8'd0, held});
    chk("ovr_hold_busy", {31'd0, busy}, 32'd1);
    out_ready = 1'b1;
    @(negedge clk);
    chk("ovr_release_valid", {31'd0, out_valid}, 32'd0);
    chk("ovr_release_busy", {31'd0, busy}, 32'd0);

    // Reset at E0+2 abandons the sample and clears accumulators
    do_reset();
    send(32'h1000_0000, 2'b01);
    get_sample("pre", s);
    send(32'h1000_0000, 2'b01);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    chk("midrst_valid", {31'd0, out_valid}, 32'd0);
    chk("midrst_busy", {31'd0, busy}, 32'd0);
    send(32'h1000_0000, 2'b01);
    get_sample("postrst", s);
    chk("postrst_sample", {8'd0, s}, 32'h0007_4000);
    @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
